// File: rtl/pipe_pkg.sv
// pipe_pkg: shared fetch-state encoding and datapath constants for the prefetch queue
package pipe_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} fetch_state_t;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: instruction-memory bus plus IF-side consume/redirect signals
interface inst_prefetch_queue_if;
  import pipe_pkg::*;
  logic memReq;
  logic [INST_W-1:0] memAddr;
  logic memAck;
  logic [INST_W-1:0] memData;
  logic take;
  logic redirect;
  logic [INST_W-1:0] redirectPc;
  logic instValid;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] instPc;
  modport master (
    output memReq, memAddr, instValid, inst, instPc,
    input memAck, memData, take, redirect, redirectPc
  );
  modport slave (
    input memReq, memAddr, instValid, inst, instPc,
    output memAck, memData, take, redirect, redirectPc
  );
endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry {pc, inst} buffer with flush; head reads zero when empty
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = count != '0 ? mem[rptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= push ? wptr + AW'(1) : wptr;
      rptr <= do_pop ? rptr + AW'(1) : rptr;
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher; redirect flushes buffer and in-flight fetch
module inst_prefetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic clk,
  input logic rst,
  inst_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state;
  logic [INST_W-1:0] fetch_pc, mem_addr, tgt;
  logic mem_req, push, pop, room;
  logic [CW-1:0] count;
  logic [2*INST_W-1:0] head;
  assign pop = bus.take && count != '0;
  assign push = state == WAIT && bus.memAck && !bus.redirect;
  // occupancy after this edge's events; a redirect empties the buffer so room is guaranteed
  assign room = bus.redirect || (count + CW'(push) - CW'(pop)) < CW'(DEPTH);
  assign tgt = bus.redirect ? bus.redirectPc : fetch_pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_addr <= '0;
    end else
      case (state)
        IDLE:
          if (room) begin
            state <= WAIT;
            mem_req <= 1'b1;
            mem_addr <= tgt;
            fetch_pc <= tgt;
          end
        WAIT:
          if (bus.redirect) begin
            fetch_pc <= bus.redirectPc;
            if (bus.memAck) mem_addr <= bus.redirectPc;
            else state <= WAIT_DROP;
          end else if (bus.memAck) begin
            fetch_pc <= fetch_pc + PC_STEP;
            mem_addr <= fetch_pc + PC_STEP;
            if (!room) begin
              state <= IDLE;
              mem_req <= 1'b0;
            end
          end
        WAIT_DROP: begin
          // the stale request must complete before the new target can be issued
          fetch_pc <= tgt;
          if (bus.memAck) begin
            state <= WAIT;
            mem_addr <= tgt;
          end
        end
        default: state <= IDLE;
      endcase
  fetch_fifo #(.DEPTH(DEPTH), .W(2 * INST_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(bus.redirect),
    .din({mem_addr, bus.memData}),
    .count(count),
    .head(head)
  );
  assign bus.memReq = mem_req;
  assign bus.memAddr = mem_addr;
  assign bus.instValid = count != '0;
  assign {bus.instPc, bus.inst} = head;
endmodule
